linear_layer_q_fifo_fwft_ctrl: RTL and testbench

Control and output stage of the 128-bit inter-kernel stream FIFO in the quantized Linear Layer datapath. It sits directly upstream of the shift-register storage array. It generates the storage write-enable and read address from producer/consumer handshakes, and adds a registered first-word-fall-through output stage so `if_dout` comes from a flop rather than the storage mux. Total capacity is DEPTH + 1 words.

---
 rtl/linear_layer_q_fifo_pkg.sv | 20 ++
 rtl/linear_layer_q_fifo_srl_store.sv | 45 ++++
 rtl/linear_layer_q_fifo_fwft_ctrl.sv | 101 ++++++++++
 tb/tb_linear_layer_q_fifo_fwft_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/linear_layer_q_fifo_pkg.sv
// Shared defaults and sizing helper for the Linear Layer stream FIFO.
package linear_layer_q_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 128;
  localparam int DEFAULT_ADDR_WIDTH = 2;
  localparam int DEFAULT_DEPTH      = 2;

  // Smallest width whose range covers 0..depth+1 (storage plus output register).
  function automatic int calc_cnt_width(input int depth);
    int w;
    w = 1;
    while ((2 ** w) <= (depth + 1)) begin
      w = w + 1;
    end
    return w;
  endfunction

  localparam int DEFAULT_CNT_WIDTH = calc_cnt_width(DEFAULT_DEPTH);

endpackage

// File: rtl/linear_layer_q_fifo_srl_store.sv
// Shift-register word storage: entry 0 takes the newest word, read is a mux on addr.
module linear_layer_q_fifo_srl_store
  import linear_layer_q_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] srl_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      srl_q[0] <= din;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_shift
      always_ff @(posedge clk) begin
        if (we) begin
          srl_q[gi] <= srl_q[gi-1];
        end
      end
    end
  endgenerate

  // Out-of-range addresses (only seen when the storage is empty) read as zero.
  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_WIDTH'(i)) begin
        dout = srl_q[i];
      end
    end
  end

endmodule

// File: rtl/linear_layer_q_fifo_fwft_ctrl.sv
// FIFO control with a registered first-word-fall-through output stage; holds DEPTH+1 words.
module linear_layer_q_fifo_fwft_ctrl
  import linear_layer_q_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [CNT_WIDTH-1:0]  if_num_data_valid,
  output logic [CNT_WIDTH-1:0]  if_fifo_cap
);

  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  ov_q, ov_d;
  logic [DATA_WIDTH-1:0] oreg_q, oreg_d;
  logic                  full_n_q, full_n_d;

  logic                  push;
  logic                  pop;
  logic                  load;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] store_dout;

  assign push = if_write & if_write_ce & full_n_q;
  assign pop  = if_read & if_read_ce & ov_q;
  assign load = ~ov_q | pop;
  assign addr = ADDR_WIDTH'(cnt_q - CNT_WIDTH'(1));

  linear_layer_q_fifo_srl_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_store (
    .clk  (clk),
    .we   (we),
    .addr (addr),
    .din  (if_din),
    .dout (store_dout)
  );

  always_comb begin
    cnt_d  = cnt_q;
    ov_d   = ov_q;
    oreg_d = oreg_q;
    we     = 1'b0;
    if (load) begin
      if (cnt_q == '0) begin
        // Empty storage: a new word bypasses straight into the output register.
        ov_d = push;
        if (push) begin
          oreg_d = if_din;
        end
      end else begin
        oreg_d = store_dout;
        ov_d   = 1'b1;
        if (push) begin
          we = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
    end else if (push) begin
      we    = 1'b1;
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
    full_n_d = (cnt_d != CNT_WIDTH'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      ov_q     <= 1'b0;
      oreg_q   <= '0;
      full_n_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      ov_q     <= ov_d;
      oreg_q   <= oreg_d;
      full_n_q <= full_n_d;
    end
  end

  assign if_full_n         = full_n_q;
  assign if_empty_n        = ov_q;
  assign if_dout           = oreg_q;
  assign if_num_data_valid = cnt_q + CNT_WIDTH'(ov_q);
  assign if_fifo_cap       = CNT_WIDTH'(DEPTH + 1);

endmodule

// File: tb/tb_linear_layer_q_fifo_fwft_ctrl.sv
// Directed and scoreboarded checks of the FWFT FIFO controller at its default sizes.
module tb_linear_layer_q_fifo_fwft_ctrl;

  localparam int DW = 128;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_write_ce = 1'b0;
  logic          if_write = 1'b0;
  logic [DW-1:0] if_din = '0;
  logic          if_full_n;
  logic          if_read_ce = 1'b0;
  logic          if_read = 1'b0;
  logic [DW-1:0] if_dout;
  logic          if_empty_n;
  logic [CW-1:0] if_num_data_valid;
  logic [CW-1:0] if_fifo_cap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  linear_layer_q_fifo_fwft_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .if_write_ce       (if_write_ce),
    .if_write          (if_write),
    .if_din            (if_din),
    .if_full_n         (if_full_n),
    .if_read_ce        (if_read_ce),
    .if_read           (if_read),
    .if_dout           (if_dout),
    .if_empty_n        (if_empty_n),
    .if_num_data_valid (if_num_data_valid),
    .if_fifo_cap       (if_fifo_cap)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_write_ce = 1'b1;
    if_read_ce = 1'b1;
    repeat (2) step();
    checks++; if (if_empty_n !== 1'b0) begin errors++; $display("FAIL reset_empty_n got %0b want 0", if_empty_n); end
    checks++; if (if_full_n !== 1'b1) begin errors++; $display("FAIL reset_full_n got %0b want 1", if_full_n); end
    checks++; if (if_dout !== '0) begin errors++; $display("FAIL reset_dout got %0h want 0", if_dout); end
    checks++; if (if_num_data_valid !== 2'd0) begin errors++; $display("FAIL reset_count got %0d want 0", if_num_data_valid); end
    checks++; if (if_fifo_cap !== 2'd3) begin errors++; $display("FAIL fifo_cap got %0d want 3", if_fifo_cap); end
    rst_n = 1'b1;
    step();
    if_read = 1'b1;
    repeat (2) step();
    if_read = 1'b0;
    checks++; if (if_num_data_valid !== 2'd0) begin errors++; $display("FAIL empty_read_count got %0d want 0", if_num_data_valid); end
    checks++; if (if_empty_n !== 1'b0) begin errors++; $display("FAIL empty_read_empty_n got %0b want 0", if_empty_n); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    if_din = 128'hA1;
    if_write = 1'b1;
    step();
    if_write = 1'b0;
    checks++; if (if_empty_n !== 1'b1) begin errors++; $display("FAIL single_empty_n got %0b want 1", if_empty_n); end
    checks++; if (if_dout !== 128'hA1) begin errors++; $display("FAIL single_dout got %0h want a1", if_dout); end
    checks++; if (if_num_data_valid !== 2'd1) begin errors++; $display("FAIL single_count got %0d want 1", if_num_data_valid); end
    if_read = 1'b1;
    step();
    if_read = 1'b0;
    checks++; if (if_empty_n !== 1'b0) begin errors++; $display("FAIL single_pop_empty_n got %0b want 0", if_empty_n); end
    checks++; if (if_num_data_valid !== 2'd0) begin errors++; $display("FAIL single_pop_count got %0d want 0", if_num_data_valid); end
    $display("test_single done");
  endtask

  task automatic test_fill_drain();
    logic [CW-1:0] exp_cnt [3];
    logic          exp_fn  [3];
    exp_cnt = '{2'd1, 2'd2, 2'd3};
    exp_fn  = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      if_din = DW'(i + 1);
      if_write = 1'b1;
      step();
      checks++; if (if_num_data_valid !== exp_cnt[i]) begin errors++; $display("FAIL fill_count[%0d] got %0d want %0d", i, if_num_data_valid, exp_cnt[i]); end
      checks++; if (if_full_n !== exp_fn[i]) begin errors++; $display("FAIL fill_full_n[%0d] got %0b want %0b", i, if_full_n, exp_fn[i]); end
    end
    if_din = 128'h4;
    step();
    if_write = 1'b0;
    checks++; if (if_num_data_valid !== 2'd3) begin errors++; $display("FAIL full_write_count got %0d want 3", if_num_data_valid); end
    checks++; if (if_dout !== 128'h1) begin errors++; $display("FAIL full_write_dout got %0h want 1", if_dout); end
    if_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (if_dout !== DW'(i + 1)) begin errors++; $display("FAIL drain_dout[%0d] got %0h want %0h", i, if_dout, i + 1); end
      step();
      checks++; if (if_full_n !== 1'b1) begin errors++; $display("FAIL drain_full_n[%0d] got %0b want 1", i, if_full_n); end
      checks++; if (if_num_data_valid !== CW'(2 - i)) begin errors++; $display("FAIL drain_count[%0d] got %0d want %0d", i, if_num_data_valid, 2 - i); end
    end
    if_read = 1'b0;
    checks++; if (if_empty_n !== 1'b0) begin errors++; $display("FAIL drain_empty_n got %0b want 0", if_empty_n); end
    $display("test_fill_drain done");
  endtask

  task automatic test_back_to_back();
    int bad;
    bad = 0;
    if_write = 1'b1;
    if_read = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if_din = DW'(32'h1000 + i);
      step();
      checks++;
      if (if_dout !== DW'(32'h1000 + i) || if_empty_n !== 1'b1 || if_num_data_valid !== 2'd1) begin
        errors++;
        bad++;
        if (bad < 8) $display("FAIL stream[%0d] dout=%0h empty_n=%0b count=%0d want dout=%0h empty_n=1 count=1",
                              i, if_dout, if_empty_n, if_num_data_valid, 32'h1000 + i);
      end
    end
    if_write = 1'b0;
    step();
    if_read = 1'b0;
    checks++; if (if_empty_n !== 1'b0) begin errors++; $display("FAIL stream_end_empty_n got %0b want 0", if_empty_n); end
    $display("test_back_to_back done");
  endtask

  task automatic test_random();
    logic [DW-1:0] q [$];
    logic          do_push, do_pop;
    int            bad;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      if_write_ce = 1'($urandom);
      if_read_ce  = 1'($urandom);
      if_write    = 1'($urandom);
      if_read     = 1'($urandom);
      if_din      = {$urandom, $urandom, $urandom, $urandom};
      do_push = if_write && if_write_ce && (q.size() < 3);
      do_pop  = if_read && if_read_ce && (q.size() > 0);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(if_din);
      step();
      checks++;
      if (if_num_data_valid !== CW'(q.size()) || if_empty_n !== (q.size() > 0) ||
          if_full_n !== (q.size() < 3) || (q.size() > 0 && if_dout !== q[0])) begin
        errors++;
        bad++;
        if (bad < 8) $display("FAIL random[%0d] count=%0d empty_n=%0b full_n=%0b dout=%0h want count=%0d head=%0h",
                              i, if_num_data_valid, if_empty_n, if_full_n, if_dout, q.size(),
                              (q.size() > 0) ? q[0] : '0);
      end
    end
    if_write_ce = 1'b1;
    if_read_ce  = 1'b1;
    if_write    = 1'b0;
    if_read     = 1'b0;
    $display("test_random done");
  endtask

  task automatic test_reset_midstream();
    if_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if_din = DW'(8'hE0 + i);
      step();
    end
    if_write = 1'b0;
    checks++; if (if_full_n !== 1'b0) begin errors++; $display("FAIL pre_reset_full_n got %0b want 0", if_full_n); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (if_full_n !== 1'b1) begin errors++; $display("FAIL async_reset_full_n got %0b want 1", if_full_n); end
    checks++; if (if_num_data_valid !== 2'd0) begin errors++; $display("FAIL async_reset_count got %0d want 0", if_num_data_valid); end
    step();
    rst_n = 1'b1;
    step();
    if_din = 128'h55;
    if_write = 1'b1;
    step();
    if_write = 1'b0;
    checks++; if (if_dout !== 128'h55) begin errors++; $display("FAIL post_reset_dout got %0h want 55", if_dout); end
    checks++; if (if_num_data_valid !== 2'd1) begin errors++; $display("FAIL post_reset_count got %0d want 1", if_num_data_valid); end
    if_read = 1'b1;
    step();
    if_read = 1'b0;
    checks++; if (if_empty_n !== 1'b0) begin errors++; $display("FAIL post_reset_stale got empty_n=%0b dout=%0h want empty_n=0", if_empty_n, if_dout); end
    $display("test_reset_midstream done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
